// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two caches, the shared system bus and the arbiter.
// The slave modport is the arbiter's view; master is the caches/bus side.
// bus_resp/bus_resptag are broadcast to both caches, so the arbiter never reads them.
interface bus_arbiter_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  // ownership handshake
  logic                      icache_busreq;
  logic                      dcache_busreq;
  logic                      icache_busidle;
  logic                      dcache_busidle;
  logic                      icache_busgrant;
  logic                      dcache_busgrant;
  // per-cache request side
  logic                      icache_bus_reqcyc;
  logic                      dcache_bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] icache_bus_req;
  logic [BUS_DATA_WIDTH-1:0] dcache_bus_req;
  logic [BUS_TAG_WIDTH-1:0]  icache_bus_reqtag;
  logic [BUS_TAG_WIDTH-1:0]  dcache_bus_reqtag;
  logic                      icache_bus_respack;
  logic                      dcache_bus_respack;
  // per-cache gated strobes
  logic                      icache_bus_reqack;
  logic                      dcache_bus_reqack;
  logic                      icache_bus_respcyc;
  logic                      dcache_bus_respcyc;
  // shared bus
  logic                      bus_reqcyc;
  logic                      bus_respack;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  // status
  logic                      arb_timeout;

  modport slave (
    input  icache_busreq, dcache_busreq, icache_busidle, dcache_busidle,
    input  icache_bus_reqcyc, dcache_bus_reqcyc, icache_bus_req, dcache_bus_req,
    input  icache_bus_reqtag, dcache_bus_reqtag, icache_bus_respack, dcache_bus_respack,
    input  bus_reqack, bus_respcyc,
    output icache_busgrant, dcache_busgrant,
    output icache_bus_reqack, dcache_bus_reqack, icache_bus_respcyc, dcache_bus_respcyc,
    output bus_reqcyc, bus_respack, bus_req, bus_reqtag,
    output arb_timeout
  );

  modport master (
    output icache_busreq, dcache_busreq, icache_busidle, dcache_busidle,
    output icache_bus_reqcyc, dcache_bus_reqcyc, icache_bus_req, dcache_bus_req,
    output icache_bus_reqtag, dcache_bus_reqtag, icache_bus_respack, dcache_bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  icache_busgrant, dcache_busgrant,
    input  icache_bus_reqack, dcache_bus_reqack, icache_bus_respcyc, dcache_bus_respcyc,
    input  bus_reqcyc, bus_respack, bus_req, bus_reqtag,
    input  arb_timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester bus arbiter (icache/dcache) with owner-selected request mux.
// Latency: grant 1 cycle after request; release 1 cycle after owner busidle.
// Backpressure: non-owner requests wait in place; one IDLE cycle between grants.
module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int HOLD_LIMIT     = 1024
) (
  input logic        clk,
  input logic        reset,
  bus_arbiter_if.slave arb
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_LIMIT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             last_owner_d;  // 1: dcache owned last, so icache wins the next tie
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // State, tie-break history, hold counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_owner_d <= 1'b1;
      hold_cnt     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (state_nxt != IDLE) begin
          last_owner_d <= (state_nxt == OWN_D);
          hold_cnt     <= '0;
        end
      end else begin
        if (hold_cnt != CNT_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        // Flag only; the grant is kept so an in-flight transaction is not cut
        if (hold_cnt == CNT_LAST) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  // Next state, grants, request mux and strobe steering from registered state
  always_comb begin
    state_nxt              = state;
    arb.icache_busgrant    = 1'b0;
    arb.dcache_busgrant    = 1'b0;
    arb.icache_bus_reqack  = 1'b0;
    arb.dcache_bus_reqack  = 1'b0;
    arb.icache_bus_respcyc = 1'b0;
    arb.dcache_bus_respcyc = 1'b0;
    arb.bus_reqcyc         = 1'b0;
    arb.bus_respack        = 1'b0;
    arb.bus_req            = {BUS_DATA_WIDTH{1'b0}};
    arb.bus_reqtag         = {BUS_TAG_WIDTH{1'b0}};
    case (state)
      IDLE: begin
        // busidle is irrelevant here; only requests decide the next owner
        if (arb.icache_busreq && arb.dcache_busreq) begin
          state_nxt = last_owner_d ? OWN_I : OWN_D;
        end else if (arb.icache_busreq) begin
          state_nxt = OWN_I;
        end else if (arb.dcache_busreq) begin
          state_nxt = OWN_D;
        end
      end
      OWN_I: begin
        arb.icache_busgrant    = 1'b1;
        arb.icache_bus_reqack  = arb.bus_reqack;
        arb.icache_bus_respcyc = arb.bus_respcyc;
        arb.bus_reqcyc         = arb.icache_bus_reqcyc;
        arb.bus_respack        = arb.icache_bus_respack;
        arb.bus_req            = arb.icache_bus_req;
        arb.bus_reqtag         = arb.icache_bus_reqtag;
        // Only the owner's busidle releases; a dropped busreq does not
        if (arb.icache_busidle) begin
          state_nxt = IDLE;
        end
      end
      OWN_D: begin
        arb.dcache_busgrant    = 1'b1;
        arb.dcache_bus_reqack  = arb.bus_reqack;
        arb.dcache_bus_respcyc = arb.bus_respcyc;
        arb.bus_reqcyc         = arb.dcache_bus_reqcyc;
        arb.bus_respack        = arb.dcache_bus_respack;
        arb.bus_req            = arb.dcache_bus_req;
        arb.bus_reqtag         = arb.dcache_bus_reqtag;
        if (arb.dcache_busidle) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arb.arb_timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus hand sequences.
// Inputs change 1ns after the rising edge; outputs are sampled at that point.
// HOLD_LIMIT is reduced to 8 so the timeout path is reachable quickly.
module tb_bus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int HL = 8;

  localparam logic [DW-1:0] I_REQ = 64'h0000_0000_0000_1000;
  localparam logic [DW-1:0] D_REQ = 64'h2000_0000_dead_beef;
  localparam logic [TW-1:0] I_TAG = 13'h0a5;
  localparam logic [TW-1:0] D_TAG = 13'h1f0;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) arb ();

  bus_arbiter #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .HOLD_LIMIT    (HL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .arb  (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic ireq;
    logic dreq;
    logic iidle;
    logic didle;
    logic exp_ig;
    logic exp_dg;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Grants, mux and strobes all follow from which cache is expected to own
  task automatic check_owner(input string tag, input logic ig, input logic dg);
    logic [DW-1:0] e_req;
    logic [TW-1:0] e_tag;
    e_req = ig ? I_REQ : (dg ? D_REQ : '0);
    e_tag = ig ? I_TAG : (dg ? D_TAG : '0);
    check({tag, " icache_busgrant"}, 64'(arb.icache_busgrant), 64'(ig));
    check({tag, " dcache_busgrant"}, 64'(arb.dcache_busgrant), 64'(dg));
    check({tag, " bus_req"}, 64'(arb.bus_req), 64'(e_req));
    check({tag, " bus_reqtag"}, 64'(arb.bus_reqtag), 64'(e_tag));
    check({tag, " bus_reqcyc"}, 64'(arb.bus_reqcyc), 64'(ig | dg));
    check({tag, " bus_respack"}, 64'(arb.bus_respack), 64'(dg));
    check({tag, " strobes i_ack,i_resp,d_ack,d_resp"},
          64'({arb.icache_bus_reqack, arb.icache_bus_respcyc,
               arb.dcache_bus_reqack, arb.dcache_bus_respcyc}),
          64'({ig, ig, dg, dg}));
  endtask

  task automatic drive(input logic ir, input logic dr, input logic ii, input logic di);
    arb.icache_busreq  = ir;
    arb.dcache_busreq  = dr;
    arb.icache_busidle = ii;
    arb.dcache_busidle = di;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(0, 0, 0, 0);
    arb.icache_bus_reqcyc  = 1'b1;
    arb.dcache_bus_reqcyc  = 1'b1;
    arb.icache_bus_req     = I_REQ;
    arb.dcache_bus_req     = D_REQ;
    arb.icache_bus_reqtag  = I_TAG;
    arb.dcache_bus_reqtag  = D_TAG;
    arb.icache_bus_respack = 1'b0;
    arb.dcache_bus_respack = 1'b1;
    arb.bus_reqack         = 1'b1;
    arb.bus_respcyc        = 1'b1;
    arb.bus_resp           = 64'h5555_aaaa_0000_ffff;
    arb.bus_resptag        = 13'h011;

    //          rst ir dr ii di   ig dg
    vecs[0]  = '{1, 0, 0, 0, 0,  0, 0};  // reset state
    vecs[1]  = '{0, 1, 0, 0, 0,  1, 0};  // lone icache request
    vecs[2]  = '{0, 0, 0, 0, 0,  1, 0};  // owner drops busreq, still owns
    vecs[3]  = '{0, 0, 0, 0, 1,  1, 0};  // non-owner busidle ignored
    vecs[4]  = '{0, 0, 1, 0, 0,  1, 0};  // dcache request pends
    vecs[5]  = '{0, 0, 1, 1, 0,  0, 0};  // icache releases: turnaround cycle
    vecs[6]  = '{0, 0, 1, 0, 0,  0, 1};  // pending dcache granted
    vecs[7]  = '{0, 1, 1, 0, 0,  0, 1};  // icache waits
    vecs[8]  = '{0, 1, 0, 0, 1,  0, 0};  // dcache releases
    vecs[9]  = '{0, 1, 0, 0, 0,  1, 0};  // icache granted
    vecs[10] = '{0, 1, 1, 1, 0,  0, 0};  // release with both pending
    vecs[11] = '{0, 1, 1, 0, 0,  0, 1};  // tie: last owner was I, so D
    vecs[12] = '{0, 1, 1, 0, 1,  0, 0};  // dcache releases
    vecs[13] = '{0, 1, 1, 0, 0,  1, 0};  // tie: last owner was D, so I
    vecs[14] = '{0, 0, 0, 1, 0,  0, 0};  // icache releases
    vecs[15] = '{0, 1, 0, 1, 0,  1, 0};  // req+idle together in IDLE: req wins
    vecs[16] = '{0, 0, 0, 1, 0,  0, 0};  // release

    for (int i = 0; i < 17; i++) begin
      reset = vecs[i].rst;
      drive(vecs[i].ireq, vecs[i].dreq, vecs[i].iidle, vecs[i].didle);
      tick();
      check_owner($sformatf("vec%0d", i), vecs[i].exp_ig, vecs[i].exp_dg);
      check($sformatf("vec%0d arb_timeout", i), 64'(arb.arb_timeout), 64'd0);
    end

    // dcache owner never idles: flag sets after 8 owning cycles, grant kept
    drive(0, 1, 0, 0);
    tick();
    check_owner("hold entry", 0, 1);
    drive(0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("hold k=%0d arb_timeout", k), 64'(arb.arb_timeout), 64'(k >= HL));
      check($sformatf("hold k=%0d dcache_busgrant", k), 64'(arb.dcache_busgrant), 64'd1);
    end
    drive(0, 0, 0, 1);
    tick();
    check_owner("after timeout release", 0, 0);
    check("timeout sticky", 64'(arb.arb_timeout), 64'd1);
    drive(0, 0, 0, 0);
    tick();
    check("timeout sticky idle", 64'(arb.arb_timeout), 64'd1);

    // Reset while dcache owns: everything back to reset values
    drive(0, 1, 0, 0);
    tick();
    check_owner("pre-reset own D", 0, 1);
    reset = 1'b1;
    tick();
    check_owner("mid-own reset", 0, 0);
    check("mid-own reset arb_timeout", 64'(arb.arb_timeout), 64'd0);
    reset = 1'b0;
    drive(0, 0, 0, 0);

    // Four ties after reset alternate I, D, I, D with a turnaround between
    for (int t = 0; t < 4; t++) begin
      logic to_i;
      to_i = (t % 2 == 0);
      drive(1, 1, 0, 0);
      tick();
      check_owner($sformatf("tie%0d", t), to_i, !to_i);
      drive(1, 1, to_i, !to_i);
      tick();
      check_owner($sformatf("tie%0d release", t), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
